// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared types and constants for the memory stage.
//
// Contents:
//   XLEN_DEFAULT : default data/address width
//   size_e       : access size encoding carried on req_size
//   state_e      : response FSM states (also exported on mem_stage.dbg_state)
package mem_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stage_ram.sv
// mem_stage_ram -- word array with per-byte write enables.
//
// One write port (we/be/waddr/wdata, committed on the rising edge of clk)
// and one asynchronous read port (raddr -> rdata). Contents are never
// cleared; there is no reset.
//
// Ports:
//   clk    : clock
//   we     : write enable
//   be     : byte-lane enables, bit i covers wdata[8*i +: 8]
//   waddr  : word index for the write
//   wdata  : write data, already placed in its byte lanes
//   raddr  : word index for the read
//   rdata  : word currently stored at raddr
module mem_stage_ram #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int LANES      = XLEN / 8,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LANES-1:0] be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- load/store stage in front of a byte-lane word array.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1 (the "acceptance edge"). req_valid may be held; the
// payload must stay stable until it transfers. The response is a one-cycle
// resp_valid strobe exactly 1+WAIT_STATES cycles after the acceptance edge;
// there is no backpressure on the response. resp_rdata/resp_err hold their
// values while resp_valid is 0.
//
// Stores commit and loads sample the array on the acceptance edge, so the
// load result is captured then and only presented later.
//
// Parameters:
//   XLEN        : data/address width (lane arithmetic assumes 32-bit words)
//   DEPTH_WORDS : number of words in the array, power of two
//   WAIT_STATES : extra cycles before each response, 0..7
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_rnw       : 1 = load, 0 = store
//   req_size      : 00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned  : 1 = zero-extend loads, 0 = sign-extend
//   req_addr      : byte address
//   req_wdata     : store data, LSB-aligned
//   resp_valid    : response strobe
//   resp_rdata    : extended load data (0 for stores and errors)
//   resp_err      : access failed (out of range, reserved size, trapped misalign)
//   busy          : FSM not in IDLE
//   dbg_state     : current FSM state
//
// Build option: define MEM_STAGE_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into errors. Without it the offending low address bits are ignored.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_rnw,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            busy,
    output state_e          dbg_state
);

    localparam int LANES = XLEN / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // First byte address past the array, one bit wider than the address so
    // the comparison cannot wrap.
    localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(DEPTH_WORDS) << 2;
    localparam logic [2:0]    WAIT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e          state;
    logic [2:0]      wait_cnt;
    logic [XLEN-1:0] pend_rdata;
    logic            pend_err;

    size_e           size;
    logic            accept;
    logic            out_of_range;
    logic            acc_err;
    logic [1:0]      lane_off;
    logic [LANES-1:0] base_be;
    logic [LANES-1:0] wr_be;
    logic [XLEN-1:0] wr_data;
    logic            wr_en;
    logic [IDX_W-1:0] word_idx;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_val;

    // Ready is withheld during reset so nothing can be accepted then.
    assign req_ready = !reset && (state != ST_WAIT);
    assign accept    = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    assign size         = size_e'(req_size);
    assign word_idx     = req_addr[IDX_W+1:2];
    assign out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);

    // Lane offset of the access; half/word offsets drop the low bits so a
    // misaligned access lands on the enclosing aligned unit.
    always_comb begin
        lane_off = 2'b00;
        base_be  = '0;
        case (size)
            SIZE_BYTE: begin
                lane_off   = req_addr[1:0];
                base_be[0] = 1'b1;
            end
            SIZE_HALF: begin
                lane_off     = {req_addr[1], 1'b0};
                base_be[1:0] = 2'b11;
            end
            SIZE_WORD: begin
                base_be = '1;
            end
            default: begin
                base_be = '0;
            end
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((size == SIZE_HALF) && req_addr[0]) ||
                        ((size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign acc_err    = out_of_range || (size == SIZE_RSVD) || misaligned;
`else
    assign acc_err    = out_of_range || (size == SIZE_RSVD);
`endif

    assign wr_be   = base_be << lane_off;
    assign wr_data = req_wdata << {lane_off, 3'b000};
    assign wr_en   = accept && !req_rnw && !acc_err;

    mem_stage_ram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .be    (wr_be),
        .waddr (word_idx),
        .wdata (wr_data),
        .raddr (word_idx),
        .rdata (rd_word)
    );

    assign rd_shift = rd_word >> {lane_off, 3'b000};

    // Stores and failed accesses respond with zero data.
    always_comb begin
        load_val = '0;
        if (req_rnw && !acc_err) begin
            case (size)
                SIZE_BYTE: load_val = req_unsigned ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                                   : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
                SIZE_HALF: load_val = req_unsigned ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                                   : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
                SIZE_WORD: load_val = rd_shift;
                default:   load_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 3'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_val;
                            resp_err   <= acc_err;
                        end else begin
                            state      <= ST_WAIT;
                            wait_cnt   <= WAIT_LOAD;
                            pend_rdata <= load_val;
                            pend_err   <= acc_err;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= pend_rdata;
                        resp_err   <= pend_err;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed bench for mem_stage.
// dut0 runs with WAIT_STATES=0, dut3 with WAIT_STATES=3; both 32-bit, 1024 words.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut0 (no wait states) ----------------
    logic        reset0, req_valid0, req_ready0, req_rnw0, req_unsigned0;
    logic [1:0]  req_size0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic        resp_valid0, resp_err0, busy0;
    state_e      dbg_state0;

    mem_stage #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_rnw(req_rnw0), .req_size(req_size0), .req_unsigned(req_unsigned0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0), .dbg_state(dbg_state0)
    );

    // ---------------- dut3 (three wait states) ----------------
    logic        reset3, req_valid3, req_ready3, req_rnw3, req_unsigned3;
    logic [1:0]  req_size3;
    logic [31:0] req_addr3, req_wdata3, resp_rdata3;
    logic        resp_valid3, resp_err3, busy3;
    state_e      dbg_state3;

    mem_stage #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_rnw(req_rnw3), .req_size(req_size3), .req_unsigned(req_unsigned3),
        .req_addr(req_addr3), .req_wdata(req_wdata3), .resp_valid(resp_valid3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3), .busy(busy3), .dbg_state(dbg_state3)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];   // {err, rdata} expected from dut0, in order

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every dut0 response is matched against the next expected entry.
    always @(negedge clk) begin
        if (resp_valid0) begin
            if (exp_q.size() == 0) begin
                check("resp0_unexpected", 33'd1, 33'd0);
            end else begin
                check("resp0_data", {resp_err0, resp_rdata0}, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue0(input string tag, input logic rnw, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rd);
        req_valid0 = 1'b1; req_rnw0 = rnw; req_size0 = size; req_unsigned0 = uns;
        req_addr0 = addr; req_wdata0 = wdata;
        #1;
        check({tag, "_ready"}, {32'd0, req_ready0}, 33'd1);
        @(posedge clk);
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        check({tag, "_lat"}, {32'd0, resp_valid0}, 33'd1);
    endtask

    task automatic idle0(input int n);
        req_valid0 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at the first negedge after acceptance; scans for resp_valid3.
    task automatic wait_resp3(input string tag, input int exp_lat,
                              input logic exp_err, input logic [31:0] exp_rd);
        int n = 1;
        while (!resp_valid3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 33'(n), 33'(exp_lat));
        check({tag, "_data"}, {resp_err3, resp_rdata3}, {exp_err, exp_rd});
    endtask

    task automatic issue3(input string tag, input logic rnw, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rd);
        int n = 0;
        while (!req_ready3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid3 = 1'b1; req_rnw3 = rnw; req_size3 = size; req_unsigned3 = uns;
        req_addr3 = addr; req_wdata3 = wdata;
        #1;
        check({tag, "_ready"}, {32'd0, req_ready3}, 33'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        wait_resp3(tag, 4, exp_err, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        mis_trap;
    logic [31:0] mis_lw22, mis_lh21, mis_lw44;
    int          seen;

    initial begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        mis_trap = 1'b1;
        mis_lw22 = 32'h0;        mis_lh21 = 32'h0;        mis_lw44 = 32'h1357_2468;
`else
        mis_trap = 1'b0;
        mis_lw22 = 32'hAB00_80F0; mis_lh21 = 32'hFFFF_80F0; mis_lw44 = 32'h0F0F_0F0F;
`endif
        reset0 = 1'b1; req_valid0 = 1'b0; req_rnw0 = 1'b0; req_size0 = 2'b00;
        req_unsigned0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
        reset3 = 1'b1; req_valid3 = 1'b0; req_rnw3 = 1'b0; req_size3 = 2'b00;
        req_unsigned3 = 1'b0; req_addr3 = '0; req_wdata3 = '0;
        repeat (3) @(negedge clk);
        reset0 = 1'b0; reset3 = 1'b0;
        @(negedge clk);

        // reset state
        check("rst0_resp_valid", {32'd0, resp_valid0}, 33'd0);
        check("rst0_rdata_err", {resp_err0, resp_rdata0}, 33'd0);
        check("rst0_busy", {32'd0, busy0}, 33'd0);
        check("rst0_ready", {32'd0, req_ready0}, 33'd1);
        check("rst0_state", {31'd0, dbg_state0}, {31'd0, ST_IDLE});
        check("rst3_busy", {32'd0, busy3}, 33'd0);

        // word store/load
        issue0("sw10", 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        idle0(1);
        issue0("lw10", 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
        idle0(1);

        // sub-word loads and extension
        issue0("sw20", 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0000_80F0, 1'b0, 32'h0);
        issue0("lb20",  1'b1, SIZE_BYTE, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFF_FFF0);
        issue0("lbu20", 1'b1, SIZE_BYTE, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0000_00F0);
        issue0("lh20",  1'b1, SIZE_HALF, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFF_80F0);
        issue0("lhu20", 1'b1, SIZE_HALF, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0000_80F0);
        issue0("lb21",  1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h0, 1'b0, 32'hFFFF_FF80);
        issue0("lbu21", 1'b1, SIZE_BYTE, 1'b1, 32'h21, 32'h0, 1'b0, 32'h0000_0080);
        issue0("lh22",  1'b1, SIZE_HALF, 1'b0, 32'h22, 32'h0, 1'b0, 32'h0);

        // byte/half stores touch only their lanes
        issue0("sb23",  1'b0, SIZE_BYTE, 1'b0, 32'h23, 32'h1234_56AB, 1'b0, 32'h0);
        issue0("lw20",  1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAB00_80F0);
        issue0("lb23",  1'b1, SIZE_BYTE, 1'b0, 32'h23, 32'h0, 1'b0, 32'hFFFF_FFAB);
        issue0("sh12",  1'b0, SIZE_HALF, 1'b0, 32'h12, 32'h9999_CAFE, 1'b0, 32'h0);
        issue0("lhu12", 1'b1, SIZE_HALF, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000_CAFE);
        issue0("lh12",  1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_CAFE);
        issue0("lw10b", 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE_BEEF);

        // store immediately followed by a load of the same word
        issue0("sw44", 1'b0, SIZE_WORD, 1'b0, 32'h44, 32'h1357_2468, 1'b0, 32'h0);
        issue0("lw44", 1'b1, SIZE_WORD, 1'b0, 32'h44, 32'h0, 1'b0, 32'h1357_2468);
        idle0(1);
        check("hold0_valid", {32'd0, resp_valid0}, 33'd0);
        check("hold0_data", {resp_err0, resp_rdata0}, {1'b0, 32'h1357_2468});
        check("hold0_busy", {32'd0, busy0}, 33'd0);

        // out-of-range and reserved size
        issue0("sw00",   1'b0, SIZE_WORD, 1'b0, 32'h0,    32'h0BAD_F00D, 1'b0, 32'h0);
        issue0("lw1000", 1'b1, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
        issue0("sw1000", 1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h7777_7777, 1'b1, 32'h0);
        issue0("lw00",   1'b1, SIZE_WORD, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0BAD_F00D);
        issue0("lrsvd",  1'b1, SIZE_RSVD, 1'b0, 32'h10,   32'h0, 1'b1, 32'h0);
        issue0("srsvd",  1'b0, SIZE_RSVD, 1'b0, 32'h10,   32'h0, 1'b1, 32'h0);
        issue0("lw10c",  1'b1, SIZE_WORD, 1'b0, 32'h10,   32'h0, 1'b0, 32'hCAFE_BEEF);
        issue0("swffc",  1'b0, SIZE_WORD, 1'b0, 32'hFFC,  32'h5A5A_5A5A, 1'b0, 32'h0);
        issue0("lwffc",  1'b1, SIZE_WORD, 1'b0, 32'hFFC,  32'h0, 1'b0, 32'h5A5A_5A5A);
        issue0("lbfff",  1'b1, SIZE_BYTE, 1'b0, 32'hFFF,  32'h0, 1'b0, 32'h0000_005A);

        // misaligned accesses
        issue0("lw22",  1'b1, SIZE_WORD, 1'b0, 32'h22, 32'h0, mis_trap, mis_lw22);
        issue0("lh21",  1'b1, SIZE_HALF, 1'b0, 32'h21, 32'h0, mis_trap, mis_lh21);
        issue0("sw46",  1'b0, SIZE_WORD, 1'b0, 32'h46, 32'h0F0F_0F0F, mis_trap, 32'h0);
        issue0("lw44b", 1'b1, SIZE_WORD, 1'b0, 32'h44, 32'h0, 1'b0, mis_lw44);

        // request held during reset must not be accepted
        issue0("sw40", 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h1111_1111, 1'b0, 32'h0);
        issue0("lw40", 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1111_1111);
        reset0 = 1'b1;
        req_valid0 = 1'b1; req_rnw0 = 1'b0; req_size0 = SIZE_WORD;
        req_addr0 = 32'h40; req_wdata0 = 32'h2222_2222;
        repeat (2) @(negedge clk);
        reset0 = 1'b0; req_valid0 = 1'b0;
        #1;
        check("rst0b_busy", {32'd0, busy0}, 33'd0);
        check("rst0b_data", {resp_err0, resp_rdata0}, 33'd0);
        check("rst0b_ready", {32'd0, req_ready0}, 33'd1);
        @(negedge clk);
        issue0("lw40b", 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1111_1111);
        idle0(2);
        check("q0_drained", 33'(exp_q.size()), 33'd0);

        // ---------------- WAIT_STATES = 3 ----------------
        issue3("sw08", 1'b0, SIZE_WORD, 1'b0, 32'h8, 32'hA5A5_A5A5, 1'b0, 32'h0);
        @(negedge clk);

        // acceptance edge ends "cycle 10"; second request held from cycle 11
        req_valid3 = 1'b1; req_rnw3 = 1'b1; req_size3 = SIZE_WORD; req_unsigned3 = 1'b0;
        req_addr3 = 32'h8; req_wdata3 = 32'h0;
        #1;
        check("ws_ready10", {32'd0, req_ready3}, 33'd1);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_rnw3 = 1'b0; req_addr3 = 32'hC; req_wdata3 = 32'hC0FF_EE00;
                check("ws_state11", {31'd0, dbg_state3}, {31'd0, ST_WAIT});
            end
            check($sformatf("ws_ready_c%0d", 10 + k), {32'd0, req_ready3}, 33'd0);
            check($sformatf("ws_valid_c%0d", 10 + k), {32'd0, resp_valid3}, 33'd0);
            check($sformatf("ws_busy_c%0d", 10 + k), {32'd0, busy3}, 33'd1);
        end
        @(negedge clk);
        check("ws_valid_c14", {32'd0, resp_valid3}, 33'd1);
        check("ws_data_c14", {resp_err3, resp_rdata3}, {1'b0, 32'hA5A5_A5A5});
        check("ws_ready_c14", {32'd0, req_ready3}, 33'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        check("ws_valid_c15", {32'd0, resp_valid3}, 33'd0);
        check("ws_ready_c15", {32'd0, req_ready3}, 33'd0);
        check("ws_hold_c15", {resp_err3, resp_rdata3}, {1'b0, 32'hA5A5_A5A5});
        wait_resp3("held_sw0c", 4, 1'b0, 32'h0);
        @(negedge clk);
        issue3("lw0c", 1'b1, SIZE_WORD, 1'b0, 32'hC, 32'h0, 1'b0, 32'hC0FF_EE00);
        @(negedge clk);

        // reset in WAIT aborts the response but keeps the committed store
        req_valid3 = 1'b1; req_rnw3 = 1'b0; req_size3 = SIZE_WORD;
        req_addr3 = 32'h30; req_wdata3 = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        check("abort_in_wait", {31'd0, dbg_state3}, {31'd0, ST_WAIT});
        reset3 = 1'b1;
        @(negedge clk);
        reset3 = 1'b0;
        #1;
        check("abort_busy", {32'd0, busy3}, 33'd0);
        check("abort_valid", {32'd0, resp_valid3}, 33'd0);
        check("abort_ready", {32'd0, req_ready3}, 33'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid3) seen++;
        end
        check("abort_noresp", 33'(seen), 33'd0);
        issue3("lw30", 1'b1, SIZE_WORD, 1'b0, 32'h30, 32'h0, 1'b0, 32'h55);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
